// File: rtl/cf_i2c_seq_pkg.sv
// Shared constants, bus payload type and helpers for the CF_I2C transaction sequencer.
package cf_i2c_seq_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned ST_W  = 4;

  // Peripheral register offsets
  localparam logic [15:0] OFS_STATUS   = 16'h0000;
  localparam logic [15:0] OFS_CMD      = 16'h0002;
  localparam logic [15:0] OFS_DATA     = 16'h0004;
  localparam logic [15:0] OFS_PRESCALE = 16'h0006;
  localparam logic [15:0] OFS_GCLK     = 16'hFF10;

  localparam logic [SEL_W-1:0] SEL_REG  = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_GCLK = 4'b1111;

  // Register bit positions
  localparam int unsigned STATUS_BUSY_B  = 0;
  localparam int unsigned STATUS_NACK_B  = 3;
  localparam int unsigned CMD_START_B    = 8;
  localparam int unsigned CMD_READ_B     = 9;
  localparam int unsigned CMD_WMULT_B    = 11;
  localparam int unsigned CMD_STOP_B     = 12;
  localparam int unsigned DATA_VALID_B   = 8;
  localparam int unsigned DATA_LAST_B    = 9;
  localparam int unsigned GCLK_EN_B      = 0;

  localparam logic [15:0] STATUS_NACK_M = 16'(1) << STATUS_NACK_B;
  localparam logic [15:0] CMD_START_M   = 16'(1) << CMD_START_B;
  localparam logic [15:0] CMD_READ_M    = 16'(1) << CMD_READ_B;
  localparam logic [15:0] CMD_WMULT_M   = 16'(1) << CMD_WMULT_B;
  localparam logic [15:0] CMD_STOP_M    = 16'(1) << CMD_STOP_B;
  localparam logic [15:0] DATA_LAST_M   = 16'(1) << DATA_LAST_B;
  localparam logic [15:0] GCLK_EN_M     = 16'(1) << GCLK_EN_B;

  // Response error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RDINV   = 2'd3;

  // Sequencer states
  localparam logic [ST_W-1:0] ST_INIT_GCLK = 4'd0;
  localparam logic [ST_W-1:0] ST_INIT_PRE  = 4'd1;
  localparam logic [ST_W-1:0] ST_IDLE      = 4'd2;
  localparam logic [ST_W-1:0] ST_W_DATA0   = 4'd3;
  localparam logic [ST_W-1:0] ST_W_DATA1   = 4'd4;
  localparam logic [ST_W-1:0] ST_W_CMD0    = 4'd5;
  localparam logic [ST_W-1:0] ST_W_CMD1    = 4'd6;
  localparam logic [ST_W-1:0] ST_POLL      = 4'd7;
  localparam logic [ST_W-1:0] ST_CLR_NACK  = 4'd8;
  localparam logic [ST_W-1:0] ST_R_DATA    = 4'd9;
  localparam logic [ST_W-1:0] ST_RESP      = 4'd10;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
  } wb_req_t;

  function automatic logic [ADR_W-1:0] reg_adr(input logic [ADR_W-1:0] base,
                                               input logic [15:0] ofs);
    return base + {16'h0000, ofs};
  endfunction

endpackage

// File: rtl/cf_wb_master_port.sv
// Single-outstanding Wishbone master: latches a request on start, holds it until ack.
module cf_wb_master_port
  import cf_i2c_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  wb_req_t          req,
  output logic             done_c,
  output logic [DAT_W-1:0] rdata_c,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [DAT_W-1:0] m_dat_o,
  output logic [SEL_W-1:0] m_sel_o,
  output logic             m_we_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  input  logic [DAT_W-1:0] m_dat_i,
  input  logic             m_ack_i
);

  // start is ignored while a cycle is open, so the issuer may hold it level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_sel_o <= '0;
      m_we_o  <= 1'b0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
    end else if (m_cyc_o) begin
      if (m_ack_i) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
      end
    end else if (start) begin
      m_adr_o <= req.adr;
      m_dat_o <= req.dat;
      m_sel_o <= req.sel;
      m_we_o  <= req.we;
      m_cyc_o <= 1'b1;
      m_stb_o <= 1'b1;
    end
  end

  assign done_c  = m_cyc_o & m_ack_i;
  assign rdata_c = done_c ? m_dat_i : '0;

endmodule

// File: rtl/cf_i2c_seq.sv
// Register-level I2C request sequencer driving a CF_I2C peripheral over Wishbone.
module cf_i2c_seq
  import cf_i2c_seq_pkg::*;
#(
  parameter logic [ADR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0]      PRESCALE   = 16'd1,
  parameter int unsigned      POLL_LIMIT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_reg,
  input  logic [7:0]       req_wdata,
  output logic             rsp_valid,
  output logic [7:0]       rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [DAT_W-1:0] m_dat_o,
  output logic [SEL_W-1:0] m_sel_o,
  output logic             m_we_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  input  logic [DAT_W-1:0] m_dat_i,
  input  logic             m_ack_i
);

  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  logic [ST_W-1:0]  state_q, state_n;
  logic             rw_q, rw_n;
  logic [6:0]       dev_q, dev_n;
  logic [7:0]       reg_q, reg_n;
  logic [7:0]       wdata_q, wdata_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [7:0]       rdata_n;
  logic [1:0]       err_n;

  logic             bus_start;
  wb_req_t          bus_req;
  logic             bus_done_c;
  logic [DAT_W-1:0] bus_rdata_c;
  logic [DAT_W-1:0] unused_bus_rdata;

  assign unused_bus_rdata = bus_rdata_c;

  cf_wb_master_port u_port (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (bus_start),
    .req     (bus_req),
    .done_c  (bus_done_c),
    .rdata_c (bus_rdata_c),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_sel_o (m_sel_o),
    .m_we_o  (m_we_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i)
  );

  // Saturating STATUS-read counter
  assign cnt_inc = (cnt_q >= CNT_W'(POLL_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT_GCLK;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      rw_q    <= rw_n;
      dev_q   <= dev_n;
      reg_q   <= reg_n;
      wdata_q <= wdata_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    rw_n        = rw_q;
    dev_n       = dev_q;
    reg_n       = reg_q;
    wdata_n     = wdata_q;
    cnt_n       = cnt_q;
    rdata_n     = rsp_rdata;
    err_n       = rsp_err;
    bus_start   = 1'b0;
    bus_req.adr = reg_adr(BASE_ADDR, OFS_STATUS);
    bus_req.dat = '0;
    bus_req.sel = SEL_REG;
    bus_req.we  = 1'b0;

    case (state_q)
      ST_INIT_GCLK: begin
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_GCLK);
        bus_req.dat = {16'h0000, GCLK_EN_M};
        bus_req.sel = SEL_GCLK;
        bus_req.we  = 1'b1;
        if (bus_done_c) state_n = ST_INIT_PRE;
      end
      ST_INIT_PRE: begin
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_PRESCALE);
        bus_req.dat = {16'h0000, PRESCALE};
        bus_req.we  = 1'b1;
        if (bus_done_c) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          rw_n    = req_rw;
          dev_n   = req_dev;
          reg_n   = req_reg;
          wdata_n = req_wdata;
          cnt_n   = '0;
          state_n = ST_W_DATA0;
        end
      end
      ST_W_DATA0: begin
        // A read sends only the register index, so that byte is the last one
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_DATA);
        bus_req.dat = {16'h0000, (rw_q ? DATA_LAST_M : 16'h0000) | {8'h00, reg_q}};
        bus_req.we  = 1'b1;
        if (bus_done_c) state_n = rw_q ? ST_W_CMD0 : ST_W_DATA1;
      end
      ST_W_DATA1: begin
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_DATA);
        bus_req.dat = {16'h0000, DATA_LAST_M | {8'h00, wdata_q}};
        bus_req.we  = 1'b1;
        if (bus_done_c) state_n = ST_W_CMD1;
      end
      ST_W_CMD0: begin
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_CMD);
        bus_req.dat = {16'h0000, CMD_WMULT_M | CMD_START_M | {9'h000, dev_q}};
        bus_req.we  = 1'b1;
        if (bus_done_c) state_n = ST_W_CMD1;
      end
      ST_W_CMD1: begin
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_CMD);
        bus_req.dat = {16'h0000, CMD_STOP_M | CMD_START_M |
                       (rw_q ? CMD_READ_M : CMD_WMULT_M) | {9'h000, dev_q}};
        bus_req.we  = 1'b1;
        if (bus_done_c) state_n = ST_POLL;
      end
      ST_POLL: begin
        bus_start = 1'b1;
        if (bus_done_c) begin
          cnt_n = cnt_inc;
          if (bus_rdata_c[STATUS_NACK_B]) begin
            state_n = ST_CLR_NACK;
          end else if (!bus_rdata_c[STATUS_BUSY_B]) begin
            if (rw_q) begin
              state_n = ST_R_DATA;
            end else begin
              err_n   = ERR_OK;
              rdata_n = '0;
              state_n = ST_RESP;
            end
          end else if (cnt_inc >= CNT_W'(POLL_LIMIT)) begin
            err_n   = ERR_TIMEOUT;
            rdata_n = '0;
            state_n = ST_RESP;
          end
        end
      end
      ST_CLR_NACK: begin
        bus_start   = 1'b1;
        bus_req.dat = {16'h0000, STATUS_NACK_M};
        bus_req.we  = 1'b1;
        if (bus_done_c) begin
          err_n   = ERR_NACK;
          rdata_n = '0;
          state_n = ST_RESP;
        end
      end
      ST_R_DATA: begin
        bus_start   = 1'b1;
        bus_req.adr = reg_adr(BASE_ADDR, OFS_DATA);
        if (bus_done_c) begin
          if (bus_rdata_c[DATA_VALID_B]) begin
            err_n   = ERR_OK;
            rdata_n = bus_rdata_c[7:0];
          end else begin
            err_n   = ERR_RDINV;
            rdata_n = '0;
          end
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_INIT_GCLK;
      end
    endcase
  end

  // Requester-side outputs registered from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      req_ready <= (state_n == ST_IDLE);
      rsp_valid <= (state_n == ST_RESP);
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_cf_i2c_seq.sv
// Directed bench for cf_i2c_seq with a logging Wishbone slave model.
module tb_cf_i2c_seq;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [15:0] PRE  = 16'h0031;
  localparam int unsigned PLIM = 4;

  logic        clk_i, rst_i;
  logic        req_valid, req_ready, req_rw;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg, req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i;

  cf_i2c_seq #(.BASE_ADDR(BASE), .PRESCALE(PRE), .POLL_LIMIT(PLIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Slave model state: configured by the stimulus, advanced only by the slave
  int          ack_delay = 1;
  logic [31:0] stat_seq[8];
  int          stat_len  = 0;
  int          stat_base = 0;
  logic [31:0] stat_dflt = 32'h0;
  logic [31:0] data_resp = 32'h0;
  int          stat_cnt  = 0;
  int          viol      = 0;
  int          ncyc      = 0;
  int          log_n     = 0;
  logic [31:0] log_adr[128];
  logic [31:0] log_dat[128];
  logic [3:0]  log_sel[128];
  logic        log_we[128];
  int          log_t[128];
  bit          in_txn    = 0;
  int          wcnt      = 0;

  always @(negedge clk_i) begin
    ncyc++;
    if (rst_i) begin
      m_ack_i = 1'b0;
      m_dat_i = 32'h0;
      in_txn  = 0;
      wcnt    = 0;
    end else if (m_ack_i) begin
      if (m_cyc_o || m_stb_o) viol++;
      m_ack_i = 1'b0;
      m_dat_i = 32'h0;
      in_txn  = 0;
    end else if (m_cyc_o || m_stb_o) begin
      if (!(m_cyc_o && m_stb_o)) viol++;
      if (!in_txn) begin
        in_txn = 1;
        wcnt   = 0;
        if (log_n < 128) begin
          log_adr[log_n] = m_adr_o;
          log_dat[log_n] = m_dat_o;
          log_sel[log_n] = m_sel_o;
          log_we[log_n]  = m_we_o;
          log_t[log_n]   = ncyc;
          log_n++;
        end
      end else if (log_n > 0 && (m_adr_o !== log_adr[log_n-1] || m_dat_o !== log_dat[log_n-1] ||
                                 m_sel_o !== log_sel[log_n-1] || m_we_o !== log_we[log_n-1])) begin
        viol++;
      end
      wcnt++;
      if (wcnt >= ack_delay) begin
        m_ack_i = 1'b1;
        if (!m_we_o && m_adr_o == BASE) begin
          m_dat_i = (stat_cnt - stat_base < stat_len) ? stat_seq[stat_cnt - stat_base] : stat_dflt;
          stat_cnt++;
        end else if (!m_we_o && m_adr_o == BASE + 32'h4) begin
          m_dat_i = data_resp;
        end else begin
          m_dat_i = 32'h0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_txn(input string tag, input int idx, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic we);
    chk({tag, "_adr"}, log_adr[idx], adr);
    chk({tag, "_we"}, 32'(log_we[idx]), 32'(we));
    chk({tag, "_sel"}, 32'(log_sel[idx]), 32'(sel));
    if (we) chk({tag, "_dat"}, log_dat[idx], dat);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!req_ready && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, 32'(req_ready), 32'h1);
  endtask

  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
    @(negedge clk_i);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    wait_ready("req_accept");
    @(negedge clk_i);
    req_valid = 1'b0;
    req_wdata = 8'h00;
  endtask

  task automatic wait_rsp(output logic [1:0] err, output logic [7:0] rdata);
    int k = 0;
    while (!rsp_valid && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'h1);
    err   = rsp_err;
    rdata = rsp_rdata;
    @(negedge clk_i);
    chk("rsp_pulse", 32'(rsp_valid), 32'h0);
  endtask

  task automatic set_status(input int len, input logic [31:0] s0, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] dflt);
    stat_base   = stat_cnt;
    stat_len    = len;
    stat_seq[0] = s0;
    stat_seq[1] = s1;
    stat_seq[2] = s2;
    stat_dflt   = dflt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, v;
    logic [1:0] e;
    logic [7:0] d;

    rst_i = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
    req_dev = '0; req_reg = '0; req_wdata = '0;
    m_ack_i = 1'b0; m_dat_i = '0;

    // Reset values
    repeat (3) @(negedge clk_i);
    chk("rst_ctl", {28'h0, m_cyc_o, m_stb_o, m_we_o, req_ready}, 32'h0);
    chk("rst_adr", m_adr_o, 32'h0);
    chk("rst_dat", m_dat_o, 32'h0);
    chk("rst_sel", 32'(m_sel_o), 32'h0);
    chk("rst_rsp", {21'h0, rsp_valid, rsp_rdata, rsp_err}, 32'h0);

    // Init sequence: GCLK enable then PRESCALE, ready only afterwards
    b = log_n;
    rst_i = 1'b0;
    wait_ready("init_ready");
    chk("init_count", 32'(log_n - b), 32'd2);
    chk_txn("init_gclk", b, BASE + 32'hFF10, 32'h1, 4'hF, 1'b1);
    chk_txn("init_pre", b + 1, BASE + 32'h6, 32'(PRE), 4'h3, 1'b1);
    chk("init_gap", 32'(log_t[b+1] - log_t[b]), 32'd2);

    // Write, busy clears on third poll
    b = log_n; v = viol;
    set_status(3, 32'h1, 32'h1, 32'h0, 32'h1);
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp(e, d);
    chk("wr_err", 32'(e), 32'h0);
    chk("wr_rdata", 32'(d), 32'h0);
    chk("wr_count", 32'(log_n - b), 32'd6);
    chk_txn("wr_data0", b, BASE + 32'h4, 32'h010, 4'h3, 1'b1);
    chk_txn("wr_data1", b + 1, BASE + 32'h4, 32'h2A5, 4'h3, 1'b1);
    chk_txn("wr_cmd", b + 2, BASE + 32'h2, 32'h1950, 4'h3, 1'b1);
    for (int i = 3; i < 6; i++) chk_txn("wr_poll", b + i, BASE, 32'h0, 4'h3, 1'b0);
    chk("wr_gap", 32'(log_t[b+1] - log_t[b]), 32'd2);
    chk("wr_viol", 32'(viol - v), 32'h0);

    // Read with valid data
    b = log_n;
    set_status(1, 32'h0, 32'h0, 32'h0, 32'h1);
    data_resp = 32'h13C;
    do_req(1'b1, 7'h50, 8'h22, 8'h00);
    wait_rsp(e, d);
    chk("rd_err", 32'(e), 32'h0);
    chk("rd_rdata", 32'(d), 32'h3C);
    chk("rd_count", 32'(log_n - b), 32'd5);
    chk_txn("rd_data0", b, BASE + 32'h4, 32'h222, 4'h3, 1'b1);
    chk_txn("rd_cmd0", b + 1, BASE + 32'h2, 32'h0950, 4'h3, 1'b1);
    chk_txn("rd_cmd1", b + 2, BASE + 32'h2, 32'h1350, 4'h3, 1'b1);
    chk_txn("rd_poll", b + 3, BASE, 32'h0, 4'h3, 1'b0);
    chk_txn("rd_data", b + 4, BASE + 32'h4, 32'h0, 4'h3, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("rd_hold", {22'h0, rsp_rdata, rsp_err}, {22'h0, 8'h3C, 2'd0});

    // NACK reported and cleared
    b = log_n;
    set_status(1, 32'h8, 32'h0, 32'h0, 32'h1);
    do_req(1'b0, 7'h21, 8'h05, 8'h77);
    wait_rsp(e, d);
    chk("nack_err", 32'(e), 32'h1);
    chk("nack_rdata", 32'(d), 32'h0);
    chk("nack_count", 32'(log_n - b), 32'd5);
    chk_txn("nack_poll", b + 3, BASE, 32'h0, 4'h3, 1'b0);
    chk_txn("nack_clr", b + 4, BASE, 32'h0008, 4'h3, 1'b1);

    // Busy forever: exactly POLL_LIMIT status reads
    b = log_n;
    set_status(0, 32'h0, 32'h0, 32'h0, 32'h1);
    do_req(1'b0, 7'h50, 8'h10, 8'h01);
    wait_rsp(e, d);
    chk("to_err", 32'(e), 32'h2);
    chk("to_count", 32'(log_n - b), 32'd7);
    chk_txn("to_last_poll", b + 6, BASE, 32'h0, 4'h3, 1'b0);

    // Read with DATA valid clear
    b = log_n;
    set_status(1, 32'h0, 32'h0, 32'h0, 32'h1);
    data_resp = 32'h0AB;
    do_req(1'b1, 7'h3F, 8'h80, 8'h00);
    wait_rsp(e, d);
    chk("rdinv_err", 32'(e), 32'h3);
    chk("rdinv_rdata", 32'(d), 32'h0);
    chk("rdinv_count", 32'(log_n - b), 32'd5);

    // Slow slave, then reset in the middle of a bus cycle
    ack_delay = 5;
    b = log_n; v = viol;
    set_status(0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_req(1'b0, 7'h11, 8'h22, 8'h33);
    for (int k = 0; k < 100 && log_n < b + 2; k++) @(negedge clk_i);
    chk("slow_started", 32'(log_n - b), 32'd2);
    repeat (2) @(negedge clk_i);
    chk("slow_cyc_held", {30'h0, m_cyc_o, m_ack_i}, 32'h2);
    chk("slow_gap", 32'(log_t[b+1] - log_t[b]), 32'd6);
    chk("slow_viol", 32'(viol - v), 32'h0);
    rst_i = 1'b1;
    #1;
    chk("arst_bus", {29'h0, m_cyc_o, m_stb_o, m_we_o}, 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    ack_delay = 1;
    repeat (2) @(negedge clk_i);
    b = log_n;
    rst_i = 1'b0;
    wait_ready("replay_ready");
    chk("replay_count", 32'(log_n - b), 32'd2);
    chk_txn("replay_gclk", b, BASE + 32'hFF10, 32'h1, 4'hF, 1'b1);
    chk_txn("replay_pre", b + 1, BASE + 32'h6, 32'(PRE), 4'h3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
